// File: rtl/tt_um_jimktrains_vslc_spi_fetch.sv
// SPI program-fetch stage: endless sequential READ from a 25xx EEPROM, one byte per 16 clocks.
// Define VSLC_SPI_FETCH_FAST_READ_EN to use FAST_READ (0x0B) with an 8-bit dummy phase.
module tt_um_jimktrains_vslc_spi_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              hold_n,
  input  logic              cipo,
  output logic              sclk,
  output logic              copi,
  output logic              cs_n,
  output logic              sd_oe,
  output logic              byte_valid,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [3:0]        bit_counter
);

  localparam int TX_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int CNT_W = $clog2(TX_W);

`ifdef VSLC_SPI_FETCH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_CMD,
    S_ADDR,
`ifdef VSLC_SPI_FETCH_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_phase;
  logic [CNT_W-1:0]  r_bit;
  logic              r_gap;
  logic [TX_W-1:0]   r_tx;
  logic [6:0]        r_rx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_byte_addr;
  logic              r_byte_valid;

  logic w_active;
  logic w_abort;
  logic w_step;
  logic w_bit_end;
  logic w_last8;
  logic w_last_addr;
  logic w_gap_done;
  logic w_load;

  always_comb begin
    w_active = (r_state != S_IDLE) && (r_state != S_GAP);
  end

  assign w_abort     = restart & w_active;
  assign w_step      = w_active & hold_n & ~restart;
  assign w_bit_end   = w_step & r_phase;
  assign w_last8     = (r_bit == CNT_W'(7));
  assign w_last_addr = (r_bit == CNT_W'(ADDR_W - 1));
  assign w_gap_done  = (r_state == S_GAP) & ~restart & r_gap;
  assign w_load      = (r_state == S_IDLE) | w_gap_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_GAP;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_CMD;
        S_GAP:  if (w_gap_done) w_state_next = S_CMD;
        S_CMD:  if (w_bit_end && w_last8) w_state_next = S_ADDR;
`ifdef VSLC_SPI_FETCH_FAST_READ_EN
        S_ADDR:  if (w_bit_end && w_last_addr) w_state_next = S_DUMMY;
        S_DUMMY: if (w_bit_end && w_last8) w_state_next = S_DATA;
`else
        S_ADDR:  if (w_bit_end && w_last_addr) w_state_next = S_DATA;
`endif
        S_DATA: w_state_next = S_DATA;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Bit phase 0 drives sclk low (copi updates), phase 1 drives it high; a bit ends leaving phase 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= 1'b0;
      r_bit        <= '0;
      r_gap        <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_byte_addr  <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_abort) begin
        r_phase <= 1'b0;
        r_bit   <= '0;
        r_gap   <= 1'b0;
      end else if (r_state == S_GAP) begin
        r_gap <= ~restart & ~r_gap;
      end

      if (w_load) begin
        r_addr  <= start_addr;
        r_tx    <= TX_W'(READ_CMD) << (TX_W - 8);
        r_phase <= 1'b0;
        r_bit   <= '0;
      end else if (w_step) begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          case (r_state)
            S_CMD: begin
              if (w_last8) begin
                r_bit <= '0;
                r_tx  <= TX_W'(r_addr) << (TX_W - ADDR_W);
              end else begin
                r_bit <= r_bit + 1'b1;
                r_tx  <= r_tx << 1;
              end
            end
            S_ADDR: begin
              if (w_last_addr) begin
                r_bit <= '0;
                r_tx  <= '0;
              end else begin
                r_bit <= r_bit + 1'b1;
                r_tx  <= r_tx << 1;
              end
            end
`ifdef VSLC_SPI_FETCH_FAST_READ_EN
            S_DUMMY: begin
              r_bit <= w_last8 ? '0 : r_bit + 1'b1;
            end
`endif
            S_DATA: begin
              r_rx <= {r_rx[5:0], cipo};
              if (w_last8) begin
                r_bit        <= '0;
                r_data       <= {r_rx, cipo};
                r_byte_addr  <= r_addr;
                r_addr       <= r_addr + 1'b1;
                r_byte_valid <= 1'b1;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
            default: r_bit <= r_bit;
          endcase
        end
      end
    end
  end

  always_comb begin
    cs_n        = ~w_active;
    sclk        = r_phase;
    sd_oe       = 1'b0;
    copi        = 1'b0;
    bit_counter = {1'b0, r_bit[2:0]};
    case (r_state)
      S_CMD, S_ADDR: begin
        sd_oe = 1'b1;
        copi  = r_tx[TX_W-1];
      end
`ifdef VSLC_SPI_FETCH_FAST_READ_EN
      S_DUMMY: sd_oe = 1'b1;
`endif
      S_DATA: bit_counter = {1'b1, r_bit[2:0]};
      default: sd_oe = 1'b0;
    endcase
  end

  assign byte_valid = r_byte_valid;
  assign data       = r_data;
  assign byte_addr  = r_byte_addr;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_spi_fetch.sv
// Randomized bench for the SPI fetch stage against a behavioural 25xx EEPROM and byte-timing model.
`timescale 1ns/1ps
module tb_tt_um_jimktrains_vslc_spi_fetch;
  localparam int ADDR_W = 16;
`ifdef VSLC_SPI_FETCH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam int DUMMY_BITS = 8;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  localparam int DUMMY_BITS = 0;
`endif
  localparam int HDR_BITS = 8 + ADDR_W + DUMMY_BITS;
  localparam int LAT      = 2 * (HDR_BITS + 8);

  logic clk = 1'b0;
  logic rst, restart, hold_n, cipo;
  logic [ADDR_W-1:0] start_addr;
  logic sclk, copi, cs_n, sd_oe, byte_valid;
  logic [7:0] data;
  logic [ADDR_W-1:0] byte_addr;
  logic [3:0] bit_counter;

  tt_um_jimktrains_vslc_spi_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .restart(restart), .start_addr(start_addr),
    .hold_n(hold_n), .cipo(cipo), .sclk(sclk), .copi(copi), .cs_n(cs_n),
    .sd_oe(sd_oe), .byte_valid(byte_valid), .data(data),
    .byte_addr(byte_addr), .bit_counter(bit_counter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM behaviour: capture header on rising SCK, shift data out on falling SCK.
  logic [7:0]  mem [0:65535];
  logic [31:0] eep_hdr = '0;
  int          eep_rc = 0;
  int          eep_j;
  logic [15:0] eep_a;
  initial cipo = 1'b0;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      eep_rc  <= 0;
      eep_hdr <= '0;
    end else begin
      if (eep_rc < HDR_BITS) eep_hdr <= {eep_hdr[30:0], copi};
      eep_rc <= eep_rc + 1;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && eep_rc >= HDR_BITS) begin
      eep_j = eep_rc - HDR_BITS;
      eep_a = eep_hdr[DUMMY_BITS +: ADDR_W] + 16'(eep_j / 8);
      cipo <= mem[eep_a][7 - (eep_j % 8)];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int base_edge = 0;
  int total_bytes = 0;
  int stream_edge, stream_base_bytes, hold_total;
  logic [ADDR_W-1:0] stream_addr;
  logic [7:0] last_data = 8'h00;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc - base_edge);
    end
  endtask

  function automatic int edge_now();
    return cyc - base_edge;
  endfunction

  function automatic int next_due();
    return stream_edge + LAT + 16 * (total_bytes - stream_base_bytes) + hold_total;
  endfunction

  // Reference: byte n of a stream arrives LAT+16n edges after cs_n falls, plus held cycles.
  task automatic monitor();
    int nb;
    logic [ADDR_W-1:0] exp_a;
    logic [31:0] exp_hdr;
    if (byte_valid) begin
      nb    = total_bytes - stream_base_bytes;
      exp_a = stream_addr + ADDR_W'(nb);
      chk_eq("bv_edge", 32'(edge_now()), 32'(next_due()));
      chk_eq("byte_addr", 32'(byte_addr), 32'(exp_a));
      chk_eq("data", 32'(data), 32'(mem[exp_a]));
      chk_eq("bit_counter", 32'(bit_counter), 32'h8);
      if (nb == 0) begin
        exp_hdr = 32'({CMD_BYTE, stream_addr}) << DUMMY_BITS;
        chk_eq("header", eep_hdr, exp_hdr);
      end
      $display("byte edge=%0d addr=%04h data=%02h", edge_now(), byte_addr, data);
      last_data = data;
      total_bytes++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_bytes(input int n);
    int target, budget;
    target = total_bytes + n;
    budget = 120 * n + 200;
    while (total_bytes < target && budget > 0) begin
      tick();
      budget--;
    end
    if (total_bytes < target) chk_eq("byte_timeout", 32'(total_bytes), 32'(target));
  endtask

  task automatic tick_until(input int target);
    int budget;
    budget = 2000;
    while (edge_now() < target && budget > 0) begin
      tick();
      budget--;
    end
    chk_eq("reach_edge", 32'(edge_now()), 32'(target));
  endtask

  // Restart held for len cycles: cs_n stays high len+1 cycles, then a new stream starts.
  task automatic do_restart(input logic [ADDR_W-1:0] addr, input int len);
    int m;
    m = edge_now();
    start_addr = addr;
    restart = 1'b1;
    stream_addr = addr;
    stream_edge = m + len + 2;
    stream_base_bytes = total_bytes;
    hold_total = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      chk_eq("rs_cs_high", 32'(cs_n), 32'h1);
      chk_eq("rs_sclk_low", 32'(sclk), 32'h0);
    end
    restart = 1'b0;
    tick();
    chk_eq("gap_cs_high", 32'(cs_n), 32'h1);
    tick();
    chk_eq("gap_cs_low", 32'(cs_n), 32'h0);
  endtask

  task automatic do_hold(input int len, input bit strict);
    logic       s_sclk;
    logic [3:0] s_bc;
    s_sclk = sclk;
    s_bc   = bit_counter;
    hold_n = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      chk_eq("hold_cs", 32'(cs_n), 32'h0);
      if (strict) begin
        chk_eq("hold_sclk", 32'(sclk), 32'(s_sclk));
        chk_eq("hold_bitcnt", 32'(bit_counter), 32'(s_bc));
      end
    end
    hold_n = 1'b1;
    hold_total += len;
  endtask

  initial begin
    int d;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h01; mem[3] = 8'h20;
    rst = 1'b1; restart = 1'b0; hold_n = 1'b1; start_addr = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_cs_n", 32'(cs_n), 32'h1);
    chk_eq("rst_sclk", 32'(sclk), 32'h0);
    chk_eq("rst_copi", 32'(copi), 32'h0);
    chk_eq("rst_sd_oe", 32'(sd_oe), 32'h0);
    chk_eq("rst_byte_valid", 32'(byte_valid), 32'h0);
    chk_eq("rst_data", 32'(data), 32'h0);
    chk_eq("rst_byte_addr", 32'(byte_addr), 32'h0);
    chk_eq("rst_bit_counter", 32'(bit_counter), 32'h0);

    base_edge = cyc;
    rst = 1'b0;
    stream_edge = 1; stream_addr = '0; stream_base_bytes = 0; hold_total = 0;
    tick();
    chk_eq("first_cs_low", 32'(cs_n), 32'h0);
    tick_until(2 * HDR_BITS);
    chk_eq("sd_oe_hdr", 32'(sd_oe), 32'h1);
    tick();
    chk_eq("sd_oe_data", 32'(sd_oe), 32'h0);
    wait_bytes(4);

    repeat (5) tick();
    do_hold(10, 1'b1);
    wait_bytes(2);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 15)) tick();
      do_hold($urandom_range(1, 12), 1'b0);
      wait_bytes(1);
    end

    tick_until(next_due() - 8);
    do_restart(16'h0004, 1);
    wait_bytes(2);

    for (int k = 0; k < 3; k++) begin
      tick_until(next_due() - $urandom_range(2, 15));
      do_restart(16'($urandom), $urandom_range(1, 3));
      wait_bytes($urandom_range(1, 3));
    end

    // Restart lands on the edge that would complete the byte.
    d = next_due();
    tick_until(d - 1);
    start_addr = 16'h0100;
    restart = 1'b1;
    stream_addr = 16'h0100;
    stream_edge = d + 2;
    stream_base_bytes = total_bytes;
    hold_total = 0;
    tick();
    restart = 1'b0;
    chk_eq("kill_no_bv", 32'(byte_valid), 32'h0);
    chk_eq("kill_data_kept", 32'(data), 32'(last_data));
    tick();
    chk_eq("kill_gap_cs", 32'(cs_n), 32'h1);
    wait_bytes(1);

    tick_until(next_due() - 5);
    do_restart(16'hFFFE, 1);
    wait_bytes(3);

    begin
      int b;
      b = 4;
      while (sclk !== 1'b1 && b > 0) begin tick(); b--; end
      chk_eq("sclk_high_seen", 32'(sclk), 32'h1);
    end
    #2 rst = 1'b1;
    #1;
    chk_eq("async_cs_n", 32'(cs_n), 32'h1);
    chk_eq("async_sclk", 32'(sclk), 32'h0);
    chk_eq("async_data", 32'(data), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
